// File: rtl/inert_spi_seq_if.sv
// SPI monarch command bus between the inertial sequencer (master) and the SPI monarch (slave).
interface inert_spi_seq_if;
  localparam int unsigned DATA_W = 16;

  logic              snd;
  logic [DATA_W-1:0] cmd;
  logic              done;
  logic [DATA_W-1:0] resp;

  modport master (
    output snd,
    output cmd,
    input  done,
    input  resp
  );

  modport slave (
    input  snd,
    input  cmd,
    output done,
    output resp
  );
endinterface

// File: rtl/inert_spi_seq.sv
// Inertial sensor SPI sequencer: power-up wait, three config writes, then a yaw
// low/high read pair per data-ready interrupt, presented as one 16-bit sample.
module inert_spi_seq #(
  parameter int unsigned PWR_WAIT_W = 16,
  parameter logic [15:0] CFG0       = 16'h0D02,
  parameter logic [15:0] CFG1       = 16'h1160,
  parameter logic [15:0] CFG2       = 16'h1440,
  parameter logic [15:0] RD_YAWL    = 16'hA600,
  parameter logic [15:0] RD_YAWH    = 16'hA700
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  INT,
  inert_spi_seq_if.master       spi,
  output logic [15:0]           yaw,
  output logic                  vld,
  output logic                  init_done
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG0_S,
    CFG1_S,
    CFG2_S,
    IDLE,
    RD_L,
    RD_H
  } state_e;

  state_e                state_q, state_d;
  logic [PWR_WAIT_W-1:0] cnt_q, cnt_d;
  logic                  cnt_full;

  logic                  int_ff1, int_ff2;
  logic                  done_q;
  logic                  done_rise;

  logic                  snd_q, snd_d;
  logic [DATA_W-1:0]     cmd_q, cmd_d;
  logic [DATA_W-1:0]     yaw_q, yaw_d;
  logic [BYTE_W-1:0]     yaw_l_q, yaw_l_d;
  logic                  vld_q, vld_d;
  logic                  init_q, init_d;

  logic [BYTE_W-1:0]     unused_resp_hi;

  assign unused_resp_hi = spi.resp[DATA_W-1:BYTE_W];
  assign cnt_full       = &cnt_q;

  // INT is asynchronous: two-flop synchroniser. done_q resets high so a done
  // level already present when reset releases is never seen as a completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      done_q  <= spi.done;
    end
  end

  assign done_rise = spi.done & ~done_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      snd_q   <= 1'b0;
      cmd_q   <= '0;
      yaw_q   <= '0;
      yaw_l_q <= '0;
      vld_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snd_q   <= snd_d;
      cmd_q   <= cmd_d;
      yaw_q   <= yaw_d;
      yaw_l_q <= yaw_l_d;
      vld_q   <= vld_d;
      init_q  <= init_d;
    end
  end

  // Next state; every launch sets snd and the new cmd together, only from a state
  // whose previous transaction has just completed, so transactions never overlap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snd_d   = 1'b0;
    cmd_d   = cmd_q;
    yaw_d   = yaw_q;
    yaw_l_d = yaw_l_q;
    vld_d   = 1'b0;
    init_d  = init_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_full) begin
          state_d = CFG0_S;
          snd_d   = 1'b1;
          cmd_d   = CFG0;
        end else begin
          cnt_d = cnt_q + PWR_WAIT_W'(1);
        end
      end
      CFG0_S: begin
        if (done_rise) begin
          state_d = CFG1_S;
          snd_d   = 1'b1;
          cmd_d   = CFG1;
        end
      end
      CFG1_S: begin
        if (done_rise) begin
          state_d = CFG2_S;
          snd_d   = 1'b1;
          cmd_d   = CFG2;
        end
      end
      CFG2_S: begin
        if (done_rise) begin
          state_d = IDLE;
          init_d  = 1'b1;
        end
      end
      IDLE: begin
        if (int_ff2) begin
          state_d = RD_L;
          snd_d   = 1'b1;
          cmd_d   = RD_YAWL;
        end
      end
      RD_L: begin
        if (done_rise) begin
          yaw_l_d = spi.resp[BYTE_W-1:0];
          state_d = RD_H;
          snd_d   = 1'b1;
          cmd_d   = RD_YAWH;
        end
      end
      RD_H: begin
        // Both bytes land in yaw on the same edge so a reader never sees a torn sample.
        if (done_rise) begin
          yaw_d   = {spi.resp[BYTE_W-1:0], yaw_l_q};
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = PWR_WAIT;
      end
    endcase
  end

  assign spi.snd   = snd_q;
  assign spi.cmd   = cmd_q;
  assign yaw       = yaw_q;
  assign vld       = vld_q;
  assign init_done = init_q;

endmodule
